// File: rtl/store_aligner_pkg.sv
// ============================================================================
// Module   : store_aligner_pkg
// Purpose  : Shared size/state encodings and lane mask helper for store path
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package store_aligner_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BEAT_LO = 2'd1,
    BEAT_HI = 2'd2
  } state_t;

  // Reserved size yields an empty mask; such requests are rejected anyway.
  function automatic logic [3:0] size_mask(input logic [1:0] size);
    logic [3:0] m;
    case (size)
      SZ_BYTE: m = 4'b0001;
      SZ_HALF: m = 4'b0011;
      SZ_WORD: m = 4'b1111;
      default: m = 4'b0000;
    endcase
    return m;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lane_shifter.sv
// ============================================================================
// Module   : lane_shifter
// Purpose  : Positions right-justified store data and byte mask across two words
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lane_shifter
  import store_aligner_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [1:0]  size,
  output logic [63:0] shifted,
  output logic [7:0]  mask
);

  assign shifted = {32'd0, wdata} << {addr_lo, 3'b000};
  assign mask    = {4'd0, size_mask(size)} << addr_lo;

endmodule

`default_nettype wire

// File: rtl/store_aligner.sv
// ============================================================================
// Module   : store_aligner
// Purpose  : Converts byte/half/word stores into one or two word-aligned beats
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module store_aligner
  import store_aligner_pkg::*;
#(
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        done,
  output logic        err
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_size;
  logic        r_done;
  logic        r_err;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        w_capture;
  logic        w_idle;
  logic        w_hi;
  logic [1:0]  w_sh_addr;
  logic [1:0]  w_sh_size;
  logic [63:0] w_shifted;
  logic [7:0]  w_mask;
  logic        w_misaligned;

  assign w_idle = (r_state == IDLE);
  assign w_hi   = (r_state == BEAT_HI);

  // In IDLE the shifter looks at the incoming request so the accept decision
  // can see misalignment; during beats it works from the captured request.
  assign w_sh_addr = w_idle ? req_addr[1:0] : r_addr[1:0];
  assign w_sh_size = w_idle ? req_size      : r_size;

  lane_shifter u_lane_shifter (
    .addr_lo (w_sh_addr),
    .wdata   (r_wdata),
    .size    (w_sh_size),
    .shifted (w_shifted),
    .mask    (w_mask)
  );

  assign w_misaligned = |w_mask[7:4];
  assign w_capture    = w_idle && req_valid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_size  <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      r_err   <= w_err_nxt;
      if (w_capture) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_size  <= req_size;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if ((req_size == SZ_RSVD) || (w_misaligned && !SPLIT_EN)) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = BEAT_LO;
          end
        end
      end
      BEAT_LO: begin
        if (mem_ready) begin
          if (w_misaligned) begin
            w_state_nxt = BEAT_HI;
          end else begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      BEAT_HI: begin
        if (mem_ready) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_be = 4'b0000;
    case (r_state)
      BEAT_LO: mem_be = w_mask[3:0];
      BEAT_HI: mem_be = w_mask[7:4];
      default: mem_be = 4'b0000;
    endcase
  end

  assign req_ready = w_idle;
  assign mem_valid = (r_state == BEAT_LO) || w_hi;
  assign mem_addr  = {r_addr[31:2], 2'b00} + {29'd0, w_hi, 2'b00};
  assign mem_wdata = w_hi ? w_shifted[63:32] : w_shifted[31:0];
  assign done      = r_done;
  assign err       = r_err;

endmodule

`default_nettype wire
